dff_bank_pipe: RTL

//   Parametrised multi-channel register bank. Each channel is a WIDTH-bit register

---
 rtl/dff_bank_pipe.sv | 96 +++++++++
 1 files changed

// File: rtl/dff_bank_pipe.sv
// rtl/dff_bank_pipe.sv - multi-channel masked-update register bank with change detect
// and a free-running delay line that carries both value and change pulse.
module dff_bank_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              CHANNELS  = 4,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sclr,
  input  logic [CHANNELS-1:0]         en,
  input  logic [2*CHANNELS-1:0]       mode,
  input  logic [WIDTH*CHANNELS-1:0]   d,
  output logic [WIDTH*CHANNELS-1:0]   q,
  output logic [CHANNELS-1:0]         chg,
  output logic [WIDTH*CHANNELS-1:0]   q_dly,
  output logic [CHANNELS-1:0]         chg_dly
);

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_TOGL = 2'b01;
  localparam logic [1:0] MODE_SET  = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;

  logic [WIDTH*CHANNELS-1:0] q_next;
  logic [CHANNELS-1:0]       chg_next;

  genvar i;
  for (i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] q_cur;
    logic [WIDTH-1:0] d_cur;
    logic [WIDTH-1:0] nq;

    assign q_cur = q[WIDTH*i +: WIDTH];
    assign d_cur = d[WIDTH*i +: WIDTH];

    // sclr wins over en; a disabled channel never looks at d
    always_comb begin
      nq = q_cur;
      if (sclr) begin
        nq = RESET_VAL;
      end else if (en[i]) begin
        case (mode[2*i +: 2])
          MODE_LOAD: nq = d_cur;
          MODE_TOGL: nq = q_cur ^ d_cur;
          MODE_SET:  nq = q_cur | d_cur;
          MODE_CLR:  nq = q_cur & ~d_cur;
          default:   nq = q_cur;
        endcase
      end
    end

    assign q_next[WIDTH*i +: WIDTH] = nq;
    assign chg_next[i]              = (nq != q_cur);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= {CHANNELS{RESET_VAL}};
      chg <= '0;
    end else begin
      q   <= q_next;
      chg <= chg_next;
    end
  end

  if (DEPTH > 0) begin : g_dly
    logic [WIDTH*CHANNELS-1:0] q_pipe   [DEPTH];
    logic [CHANNELS-1:0]       chg_pipe [DEPTH];

    // sclr deliberately not applied here so the clear propagates like any other value
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) begin
          q_pipe[k]   <= {CHANNELS{RESET_VAL}};
          chg_pipe[k] <= '0;
        end
      end else begin
        q_pipe[0]   <= q;
        chg_pipe[0] <= chg;
        for (int k = 1; k < DEPTH; k++) begin
          q_pipe[k]   <= q_pipe[k-1];
          chg_pipe[k] <= chg_pipe[k-1];
        end
      end
    end

    assign q_dly   = q_pipe[DEPTH-1];
    assign chg_dly = chg_pipe[DEPTH-1];
  end else begin : g_nodly
    assign q_dly   = q;
    assign chg_dly = chg;
  end

endmodule
